// File: rtl/maze_actor_mover.sv
// Per-frame movement engine for one maze actor: fractional speed, queued turns,
// tunnel wrap and optional ghost-house access.
module maze_actor_mover #(
    parameter int unsigned TILE_BITS     = 3,
    parameter int unsigned X_W           = 9,
    parameter int unsigned Y_W           = 9,
    parameter int unsigned START_X       = 119,
    parameter int unsigned START_Y       = 227,
    parameter logic [1:0]  START_DIR     = 2'b00,
    parameter int unsigned Y_TILE_OFFSET = 3,
    parameter int unsigned MAZE_W_TILES  = 28,
    parameter bit          TUNNEL_WRAP   = 1'b1,
    parameter int unsigned SPEED_W       = 8,
    parameter int unsigned ANIM_DIV      = 2
) (
    input  logic                   clk60,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   turn_req,
    input  logic [1:0]             turn_dir,
    input  logic                   reverse,
    input  logic [SPEED_W:0]       speed,
    input  logic                   gh_ok,
    input  logic [0:3][1:0]        tile_info,
    output logic [X_W-1:0]         xloc,
    output logic [Y_W-1:0]         yloc,
    output logic [1:0]             dir,
    output logic [1:0]             anim_cycle,
    output logic [X_W-TILE_BITS-1:0] curr_xtile,
    output logic [Y_W-TILE_BITS-1:0] curr_ytile,
    output logic                   at_center,
    output logic                   moving,
    output logic                   tile_enter
);

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_U = 2'b01;
    localparam logic [1:0] DIR_D = 2'b10;
    localparam logic [1:0] DIR_L = 2'b11;

    localparam logic [TILE_BITS-1:0] CENTRE = TILE_BITS'((1 << (TILE_BITS - 1)) - 1);
    localparam int unsigned          MAZE_W_PX = MAZE_W_TILES << TILE_BITS;
    localparam logic [X_W-1:0]       X_LAST = X_W'(MAZE_W_PX - 1);
    localparam logic [Y_W-1:0]       Y_LAST = '1;
    localparam int unsigned          DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(ANIM_DIV - 1);
    localparam logic [SPEED_W:0]     SPEED_MAX = {1'b1, {SPEED_W{1'b0}}};

    logic [X_W-1:0]     xloc_q, xloc_d;
    logic [Y_W-1:0]     yloc_q, yloc_d;
    logic [1:0]         dir_q, dir_next;
    logic [1:0]         anim_q, anim_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SPEED_W-1:0] acc_q, acc_d;
    logic               q_valid_q, q_valid_d;
    logic [1:0]         q_dir_q, q_dir_d;
    logic               moving_q, tile_enter_q;

    logic               rev_evt, q_fire, step, blocked, edge_stop, do_move, tile_changed;
    logic [SPEED_W:0]   spd_sat, acc_sum;
    logic [X_W-1:0]     x_mv;
    logic [Y_W-1:0]     y_mv;

    function automatic logic walkable(input logic [1:0] t, input logic ok);
        return (t != 2'b00) && ((t != 2'b11) || ok);
    endfunction

    always_comb begin
        at_center = (xloc_q[TILE_BITS-1:0] == CENTRE) && (yloc_q[TILE_BITS-1:0] == CENTRE);

        // A turn request for the opposite heading is just a reversal.
        rev_evt = reverse || (turn_req && (turn_dir == ~dir_q));
        q_fire  = q_valid_q && at_center && walkable(tile_info[q_dir_q], gh_ok);

        dir_next = dir_q;
        if (rev_evt) begin
            dir_next = ~dir_q;
        end else if (q_fire) begin
            dir_next = q_dir_q;
        end

        q_valid_d = q_valid_q;
        q_dir_d   = q_dir_q;
        if (q_fire) begin
            q_valid_d = 1'b0;
        end
        if (rev_evt) begin
            q_valid_d = 1'b0;
        end else if (turn_req) begin
            if (turn_dir == dir_q) begin
                q_valid_d = 1'b0;
            end else begin
                q_valid_d = 1'b1;
                q_dir_d   = turn_dir;
            end
        end

        spd_sat = (speed >= SPEED_MAX) ? SPEED_MAX : speed;
        acc_sum = {1'b0, acc_q} + spd_sat;
        step    = acc_sum[SPEED_W];
        acc_d   = acc_sum[SPEED_W-1:0];

        blocked   = at_center && !walkable(tile_info[dir_next], gh_ok);
        edge_stop = 1'b0;
        x_mv      = xloc_q;
        y_mv      = yloc_q;
        case (dir_next)
            DIR_R: begin
                if (xloc_q == X_LAST) begin
                    x_mv      = '0;
                    edge_stop = !TUNNEL_WRAP;
                end else begin
                    x_mv = xloc_q + 1'b1;
                end
            end
            DIR_L: begin
                if (xloc_q == '0) begin
                    x_mv      = X_LAST;
                    edge_stop = !TUNNEL_WRAP;
                end else begin
                    x_mv = xloc_q - 1'b1;
                end
            end
            DIR_U: begin
                edge_stop = (yloc_q == '0);
                y_mv      = yloc_q - 1'b1;
            end
            DIR_D: begin
                edge_stop = (yloc_q == Y_LAST);
                y_mv      = yloc_q + 1'b1;
            end
            default: ;
        endcase

        do_move = step && !blocked && !edge_stop;
        xloc_d  = do_move ? x_mv : xloc_q;
        yloc_d  = do_move ? y_mv : yloc_q;

        tile_changed = (xloc_d[X_W-1:TILE_BITS] != xloc_q[X_W-1:TILE_BITS]) ||
                       (yloc_d[Y_W-1:TILE_BITS] != yloc_q[Y_W-1:TILE_BITS]);

        anim_d = anim_q;
        div_d  = div_q;
        if (do_move) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                anim_d = anim_q + 2'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end else if (anim_q == 2'd0) begin
            anim_d = 2'd1;
        end
    end

    always_ff @(posedge clk60) begin
        if (reset) begin
            xloc_q       <= X_W'(START_X);
            yloc_q       <= Y_W'(START_Y);
            dir_q        <= START_DIR;
            anim_q       <= 2'd1;
            div_q        <= '0;
            acc_q        <= '0;
            q_valid_q    <= 1'b0;
            q_dir_q      <= 2'b00;
            moving_q     <= 1'b0;
            tile_enter_q <= 1'b0;
        end else if (enable) begin
            xloc_q       <= xloc_d;
            yloc_q       <= yloc_d;
            dir_q        <= dir_next;
            anim_q       <= anim_d;
            div_q        <= div_d;
            acc_q        <= acc_d;
            q_valid_q    <= q_valid_d;
            q_dir_q      <= q_dir_d;
            moving_q     <= do_move;
            tile_enter_q <= tile_changed;
        end else begin
            moving_q     <= 1'b0;
            tile_enter_q <= 1'b0;
        end
    end

    assign xloc       = xloc_q;
    assign yloc       = yloc_q;
    assign dir        = dir_q;
    assign anim_cycle = anim_q;
    assign curr_xtile = xloc_q[X_W-1:TILE_BITS];
    assign curr_ytile = yloc_q[Y_W-1:TILE_BITS] - (Y_W - TILE_BITS)'(Y_TILE_OFFSET);
    assign moving     = moving_q;
    assign tile_enter = tile_enter_q;

endmodule

// File: tb/tb_maze_actor_mover.sv
// Directed bench for maze_actor_mover: main instance plus two tunnel-edge instances
// starting at x=0 heading LEFT, one wrapping and one holding.
module tb_maze_actor_mover;

    logic           clk60 = 1'b0;
    logic           reset, enable, turn_req, reverse, gh_ok;
    logic [1:0]     turn_dir;
    logic [8:0]     speed;
    logic [0:3][1:0] tile_info;

    logic [8:0] xloc, yloc, w_xloc, w_yloc, h_xloc, h_yloc;
    logic [1:0] dir, anim_cycle, w_dir, w_anim, h_dir, h_anim;
    logic [5:0] curr_xtile, curr_ytile, w_xtile, w_ytile, h_xtile, h_ytile;
    logic       at_center, moving, tile_enter;
    logic       w_center, w_moving, w_tile_enter, h_center, h_moving, h_tile_enter;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk60 = ~clk60;

    maze_actor_mover u_dut (
        .clk60(clk60), .reset(reset), .enable(enable), .turn_req(turn_req),
        .turn_dir(turn_dir), .reverse(reverse), .speed(speed), .gh_ok(gh_ok),
        .tile_info(tile_info), .xloc(xloc), .yloc(yloc), .dir(dir),
        .anim_cycle(anim_cycle), .curr_xtile(curr_xtile), .curr_ytile(curr_ytile),
        .at_center(at_center), .moving(moving), .tile_enter(tile_enter)
    );

    maze_actor_mover #(.START_X(0), .START_DIR(2'b11), .TUNNEL_WRAP(1'b1)) u_wrap (
        .clk60(clk60), .reset(reset), .enable(enable), .turn_req(turn_req),
        .turn_dir(turn_dir), .reverse(reverse), .speed(speed), .gh_ok(gh_ok),
        .tile_info(tile_info), .xloc(w_xloc), .yloc(w_yloc), .dir(w_dir),
        .anim_cycle(w_anim), .curr_xtile(w_xtile), .curr_ytile(w_ytile),
        .at_center(w_center), .moving(w_moving), .tile_enter(w_tile_enter)
    );

    maze_actor_mover #(.START_X(0), .START_DIR(2'b11), .TUNNEL_WRAP(1'b0)) u_hold (
        .clk60(clk60), .reset(reset), .enable(enable), .turn_req(turn_req),
        .turn_dir(turn_dir), .reverse(reverse), .speed(speed), .gh_ok(gh_ok),
        .tile_info(tile_info), .xloc(h_xloc), .yloc(h_yloc), .dir(h_dir),
        .anim_cycle(h_anim), .curr_xtile(h_xtile), .curr_ytile(h_ytile),
        .at_center(h_center), .moving(h_moving), .tile_enter(h_tile_enter)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk60);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_reverse();
        reverse = 1'b1;
        tick();
        reverse = 1'b0;
    endtask

    task automatic pulse_turn(input logic [1:0] d);
        turn_req = 1'b1;
        turn_dir = d;
        tick();
        turn_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; turn_req = 1'b0; reverse = 1'b0; gh_ok = 1'b0;
        turn_dir = 2'b00; speed = 9'd256; tile_info = {4{2'b01}};
        #2;

        // Reset values and full-speed corridor run.
        do_reset();
        check_eq("rst_x", xloc, 119);
        check_eq("rst_y", yloc, 227);
        check_eq("rst_dir", dir, 0);
        check_eq("rst_anim", anim_cycle, 1);
        check_eq("rst_moving", moving, 0);
        check_eq("rst_tile_enter", tile_enter, 0);
        check_eq("rst_xtile", curr_xtile, 14);
        check_eq("rst_ytile", curr_ytile, 25);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_eq("run_x", xloc, 119 + i);
            check_eq("run_anim", anim_cycle, ((i / 2) + 1) % 4);
            check_eq("run_moving", moving, 1);
            if (i == 1) check_eq("run_tile_enter1", tile_enter, 1);
            if (i == 2) check_eq("run_tile_enter2", tile_enter, 0);
        end

        // Speed 0, half speed, then a saturating value.
        speed = 9'd0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("spd0_x", xloc, 119);
            check_eq("spd0_anim", anim_cycle, 1);
            check_eq("spd0_moving", moving, 0);
        end
        speed = 9'd128;
        tick(); check_eq("half_x1", xloc, 119);
        tick(); check_eq("half_x2", xloc, 120);
        tick(); check_eq("half_x3", xloc, 120);
        tick(); check_eq("half_x4", xloc, 121);
        check_eq("half_anim", anim_cycle, 2);
        speed = 9'd400;
        tick(); check_eq("sat_x1", xloc, 122);
        tick(); check_eq("sat_x2", xloc, 123);

        // Wall to the right: walk to the tile centre then stop.
        speed = 9'd256;
        tile_info = {2'b00, 2'b01, 2'b01, 2'b01};
        do_reset();
        tick(); tick(); tick();
        check_eq("wall_x122", xloc, 122);
        tick(); check_eq("wall_x123", xloc, 123);
        check_eq("wall_centre", at_center, 1);
        tick(); check_eq("wall_hold_x", xloc, 123);
        check_eq("wall_moving", moving, 0);
        tick(); check_eq("wall_hold_x2", xloc, 123);

        // Queued UP turn from x=116 heading RIGHT, taken at x=123.
        tile_info = {4{2'b01}};
        do_reset();
        pulse_reverse();
        check_eq("rev_dir", dir, 3);
        check_eq("rev_x", xloc, 118);
        tick(); tick(); tick();
        check_eq("rev_x115", xloc, 115);
        pulse_reverse();
        check_eq("rev2_dir", dir, 0);
        check_eq("rev2_x", xloc, 116);
        pulse_turn(2'b01);
        check_eq("q_x117", xloc, 117);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_eq("q_wait_x", xloc, 117 + i);
            check_eq("q_wait_dir", dir, 0);
        end
        tick();
        check_eq("q_turn_dir", dir, 1);
        check_eq("q_turn_x", xloc, 123);
        check_eq("q_turn_y", yloc, 226);

        // Reverse beats a simultaneous DOWN request; queue stays empty.
        do_reset();
        reverse = 1'b1; turn_req = 1'b1; turn_dir = 2'b10;
        tick();
        reverse = 1'b0; turn_req = 1'b0;
        check_eq("rt_dir", dir, 3);
        tick(); tick(); tick();
        check_eq("rt_x115", xloc, 115);
        tick();
        check_eq("rt_noturn_dir", dir, 3);
        check_eq("rt_noturn_x", xloc, 114);
        check_eq("rt_noturn_y", yloc, 227);

        // Tunnel edge: wrap instance jumps to 223, hold instance stays at 0.
        do_reset();
        tick();
        check_eq("wrap_x", w_xloc, 223);
        check_eq("wrap_xtile", w_xtile, 27);
        check_eq("wrap_tile_enter", w_tile_enter, 1);
        check_eq("hold_x", h_xloc, 0);
        check_eq("hold_moving", h_moving, 0);
        tick();
        check_eq("wrap_x2", w_xloc, 222);
        check_eq("wrap_tile_enter2", w_tile_enter, 0);

        // Ghost-house tile below: blocked without gh_ok, taken once allowed.
        tile_info = {2'b01, 2'b01, 2'b11, 2'b01};
        gh_ok = 1'b0;
        do_reset();
        pulse_turn(2'b10);
        tick(); tick(); tick();
        check_eq("gh_x123", xloc, 123);
        tick();
        check_eq("gh_blocked_dir", dir, 0);
        check_eq("gh_blocked_x", xloc, 124);
        gh_ok = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check_eq("gh_x131", xloc, 131);
        tick();
        check_eq("gh_turn_dir", dir, 2);
        check_eq("gh_turn_y", yloc, 228);
        check_eq("gh_turn_x", xloc, 131);

        // Freeze with enable low, resume, then reset while disabled.
        tile_info = {4{2'b01}};
        gh_ok = 1'b0;
        do_reset();
        tick(); tick(); tick();
        check_eq("frz_pre_x", xloc, 122);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                turn_req = 1'b1; turn_dir = 2'b01;
            end else begin
                turn_req = 1'b0;
            end
            tick();
            check_eq("frz_x", xloc, 122);
            check_eq("frz_dir", dir, 0);
            check_eq("frz_anim", anim_cycle, 2);
            check_eq("frz_moving", moving, 0);
        end
        turn_req = 1'b0;
        enable = 1'b1;
        tick();
        check_eq("resume_x", xloc, 123);
        check_eq("resume_dir", dir, 0);
        check_eq("resume_anim", anim_cycle, 3);
        enable = 1'b0;
        do_reset();
        check_eq("dis_rst_x", xloc, 119);
        check_eq("dis_rst_y", yloc, 227);
        check_eq("dis_rst_anim", anim_cycle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
